cl_serial_ctrl: RTL and testbench
=================================

// Module: cl_serial_ctrl
// PURPOSE
//  Bit-serial sequencer for the 1-bit logic cell cl (AND/OR/XOR/NOT selected by S).
//  Latches two WIDTH-bit operands and an op code on start.
//  Drives one internal cl instance LSB-first, one bit per clock.
//  Assembles the WIDTH-bit result and pulses done.
//  Lets the datapath reuse a single 1-bit cell for word-wide logic operations.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range >= 2
// PORTS
//  clk     in   1      clock; all state updates on the rising edge
//  reset   in   1      asynchronous, active-high reset
//  start   in   1      request; sampled only in IDLE
//  op      in   2      00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored); same encoding as cl S
//  a       in   WIDTH  operand A; sampled on the accepting edge only
//  b       in   WIDTH  operand B; sampled on the accepting edge only
//  busy    out  1      high while state is RUN
//  done    out  1      one-cycle pulse; result is final
//  result  out  WIDTH  result register
// BEHAVIOUR
//  Reset (async, immediate, any state):
//   - state=IDLE, cnt=0
//   - busy=0, done=0, result=0
//   - operand shift registers and op register cleared
//  FSM states and transitions:
//   - IDLE: if start=1 at edge E0, latch a, b, op; cnt=0; go to RUN. Otherwise stay.
//   - RUN: at each edge E1..EWIDTH:
//     - cl(bit0 of sa, bit0 of sb, op_q) result bit is shifted into result MSB.
//     - result shifts right; sa and sb shift right.
//     - cnt increments.
//     - At EWIDTH (cnt==WIDTH-1), go to DONE.
//   - DONE: lasts one cycle, done=1, then IDLE at the next edge unconditionally.
//  Latency and timing:
//   - start edge to done high: WIDTH+1 edges.
//   - busy is high for exactly WIDTH cycles.
//   - Minimum start-to-start period: WIDTH+2 cycles.
//  result contents:
//   - Holds partial bits during RUN; consumers must not use it then.
//   - Stable and final from DONE until the next accepted start.
//  start handling:
//   - start in RUN or DONE is ignored, not queued.
//   - A start held high is re-accepted on the first IDLE cycle.
//  Input stability: a, b, op may change freely after the accepting edge.
//  Counter width: $clog2(WIDTH); no wrap occurs because exit is at WIDTH-1.
//  Outputs are registered (no combinational path from inputs to outputs).
//  Reset mid-RUN or mid-DONE: operation aborted, no done pulse, result=0.
// CONFIGURATION
//  CL_SERIAL_ZERO_FLAG_EN defined:
//   - Adds output port zero (1 bit, reset 0).
//   - A sticky OR of produced result bits is accumulated during RUN.
//   - zero is updated at the DONE transition: 1 iff result==0.
//   - zero holds until the next done; it is cleared when start is accepted.
//  CL_SERIAL_ZERO_FLAG_EN undefined:
//   - Port zero and its logic are absent.
//   - All other behaviour is identical.
// TESTING (WIDTH=8)
//  1. reset, a=CA, b=0F, op=00, 1-cycle start:
//     busy high 8 cycles; done at 9th edge after start; result=0A.
//  2. Same operands, op=01 -> CF; op=10 -> C5; op=11 -> 35 (b ignored).
//  3. start again with a=FF, b=FF, op=01 during RUN:
//     ignored; first result unchanged; busy not extended.
//  4. reset asserted when cnt=3 (between edges):
//     busy=0, done=0, result=00 immediately; next start returns correct result.
//  5. start held high with a=0F, b=F0, op=10:
//     done pulses every 10 cycles; result=FF each time.
//  6. With CL_SERIAL_ZERO_FLAG_EN: a=F0, b=0F, op=00 -> result=00, zero=1 with done;
//     then op=01 -> result=FF, zero=0.

Source files
------------

// File: rtl/cl_serial_ctrl.sv
// cl_serial_ctrl: bit-serial word-wide logic sequencer built around a single
// 1-bit logic cell (cl). Operands are latched on an accepted start, processed
// LSB-first one bit per clock, and the assembled result is flagged by a
// one-cycle done pulse.
//
// Optional feature: define CL_SERIAL_ZERO_FLAG_EN to add the 'zero' output,
// which reports whether the last completed result was all zeros.

// cl: 1-bit logic cell, s = 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored)
module cl (
    input  logic       a,
    input  logic       b,
    input  logic [1:0] s,
    output logic       y
);

    // Select the logic function for one bit
    always_comb begin
        y = 1'b0;
        case (s)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: y = ~a;
        endcase
    end

endmodule

module cl_serial_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef CL_SERIAL_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  sa;
    logic [WIDTH-1:0]  sb;
    logic [1:0]        op_q;
    logic              bit_y;
    logic              last;

    assign last = (cnt == CW'(WIDTH - 1));

    cl u_cl (
        .a (sa[0]),
        .b (sb[0]),
        .s (op_q),
        .y (bit_y)
    );

    // State register plus registered status outputs decoded from next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN);
            done  <= (state_nx == DONE);
        end
    end

    // Next-state logic: start only matters in IDLE; DONE always returns to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (last)  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, serial shift and result assembly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa     <= '0;
            sb     <= '0;
            op_q   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        op_q <= op;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    result <= {bit_y, result[WIDTH-1:1]};
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    // Hold on the final bit so a power-of-two WIDTH never wraps
                    if (!last) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef CL_SERIAL_ZERO_FLAG_EN
    logic acc;

    // Sticky OR of produced bits; zero resolves on the edge entering DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= 1'b0;
            zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= 1'b0;
                        zero <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc | bit_y;
                    if (last) zero <= ~(acc | bit_y);
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_cl_serial_ctrl.sv
// Self-checking bench for cl_serial_ctrl (WIDTH=8): stimulus pushes expected
// results into a queue, a monitor pops and compares on every done pulse.
module tb_cl_serial_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef CL_SERIAL_ZERO_FLAG_EN
    logic         zero;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_n = 0;
    exp_t q[$];
    int done_cyc[$];
    logic prev_done = 1'b0;

    cl_serial_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef CL_SERIAL_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            check("done_single_cycle", int'(prev_done), 0);
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("result", int'(result), int'(e.r));
`ifdef CL_SERIAL_ZERO_FLAG_EN
                check("zero", int'(zero), int'(e.z));
`endif
            end
            done_cyc.push_back(cyc);
            done_n++;
        end
        prev_done = done && !reset;
    end

    function automatic exp_t mk(input logic [W-1:0] r);
        exp_t e;
        e.r = r;
        e.z = (r == '0);
        return e;
    endfunction

    // One-cycle start pulse; optional stray start injected during RUN
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [1:0] iop, input logic [W-1:0] er,
                          input int inj_at);
        int lat;
        int bc;
        @(negedge clk);
        a = ia; b = ib; op = iop; start = 1'b1;
        q.push_back(mk(er));
        @(negedge clk);
        start = 1'b0;
        // Inputs are free to change after the accepting edge
        a = ~ia; b = ~ib; op = iop + 2'd1;
        lat = 0;
        bc = busy ? 1 : 0;
        while (!done && lat < 20) begin
            if (lat == inj_at) begin
                a = '1; b = '1; op = 2'b01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (busy) bc++;
        end
        start = 1'b0;
        check("latency", lat, W);
        check("busy_cycles", bc, W);
        @(negedge clk);
        check("idle_after_done", int'(busy | done), 0);
    endtask

    initial begin
        int t0;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
`ifdef CL_SERIAL_ZERO_FLAG_EN
        check("rst_zero", int'(zero), 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic operations on CA/0F
        run_op(8'hCA, 8'h0F, 2'b00, 8'h0A, -1);
        run_op(8'hCA, 8'h0F, 2'b01, 8'hCF, -1);
        run_op(8'hCA, 8'h0F, 2'b10, 8'hC5, -1);
        run_op(8'hCA, 8'h0F, 2'b11, 8'h35, -1);
        run_op(8'hCA, 8'h55, 2'b11, 8'h35, -1);

        // Start during RUN is ignored
        run_op(8'hCA, 8'h0F, 2'b00, 8'h0A, 3);
        repeat (3) @(negedge clk);
        check("no_queued_start", int'(busy), 0);

        // Reset mid-RUN when cnt=3
        @(negedge clk);
        a = 8'h12; b = 8'h34; op = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done_q", q.size(), 0);
        run_op(8'h3C, 8'hA5, 2'b10, 8'h99, -1);

        // Start held high: done every W+2 cycles
        @(negedge clk);
        done_cyc.delete();
        t0 = done_n;
        a = 8'h0F; b = 8'hF0; op = 2'b10; start = 1'b1;
        repeat (3) q.push_back(mk(8'hFF));
        for (int i = 0; i < 60 && done_n < t0 + 3; i++) @(negedge clk);
        start = 1'b0;
        check("held_done_count", done_n - t0, 3);
        if (done_cyc.size() >= 3) begin
            check("held_period1", done_cyc[1] - done_cyc[0], W + 2);
            check("held_period2", done_cyc[2] - done_cyc[1], W + 2);
        end
        repeat (12) @(negedge clk);
        check("held_no_extra", q.size(), 0);

`ifdef CL_SERIAL_ZERO_FLAG_EN
        run_op(8'hF0, 8'h0F, 2'b00, 8'h00, -1);
        check("zero_hold", int'(zero), 1);
        run_op(8'hF0, 8'h0F, 2'b01, 8'hFF, -1);
        check("zero_clear_hold", int'(zero), 0);
`else
        run_op(8'hF0, 8'h0F, 2'b00, 8'h00, -1);
        run_op(8'hF0, 8'h0F, 2'b01, 8'hFF, -1);
`endif
        check("final_result_stable", int'(result), 8'hFF);
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
